// File: rtl/hdmi_timing_ctrl_if.sv
// Pixel fetch bus between the timing controller and a show-ahead pixel source.
// The controller is the master and the source answers in the same cycle.
interface hdmi_timing_ctrl_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [23:0] pix_data;
  logic        pix_valid;

  modport master (
    output pix_req, pix_x, pix_y,
    input  pix_data, pix_valid
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    output pix_data, pix_valid
  );
endinterface

// File: rtl/hdmi_timing_ctrl.sv
// HDMI video timing generator: raster counters, pixel fetch, and
// registered sync/de/rgb toward the TMDS encoder.
module hdmi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  hdmi_timing_ctrl_if.master pix,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [23:0]        rgb,
  output logic               frame_start,
  output logic               underflow,
  output logic               busy
);

  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HT1 =
    12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VT1 =
    12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        h_last;
  logic        v_last;
  logic        req;
  logic        to_idle;
  logic        h_sync_on;
  logic        v_sync_on;

  assign h_last = (h_cnt == HT1);
  assign v_last = (v_cnt == VT1);
  assign h_nxt  = h_last ? 12'd0 : h_cnt + 12'd1;
  assign v_nxt  = !h_last ? v_cnt
                : (v_last ? 12'd0 : v_cnt + 12'd1);

  assign busy    = (state != IDLE);
  assign req     = busy && (h_cnt < HA) && (v_cnt < VA);
  // A frame only ends on its last cycle; enable merely decides what follows.
  assign to_idle = busy && !enable && h_last && v_last;

  assign h_sync_on = busy && (h_cnt >= HS0) && (h_cnt < HS1);
  assign v_sync_on = busy && (v_cnt >= VS0) && (v_cnt < VS1);

  assign pix.pix_req = req;
  assign pix.pix_x   = h_cnt;
  assign pix.pix_y   = v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      de          <= req;
      rgb         <= (req && pix.pix_valid) ? pix.pix_data : 24'h0;
      hsync       <= h_sync_on ? HS_POL : ~HS_POL;
      vsync       <= v_sync_on ? VS_POL : ~VS_POL;
      frame_start <= (state == RUN) && (h_cnt == 12'd0)
                     && (v_cnt == 12'd0);

      if (!busy || to_idle)
        underflow <= 1'b0;
      else if (req && !pix.pix_valid)
        underflow <= 1'b1;

      unique case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable)
            state <= RUN;
        end
        RUN: begin
          h_cnt <= h_nxt;
          v_cnt <= v_nxt;
          if (to_idle)
            state <= IDLE;
          else if (!enable)
            state <= STOPPING;
        end
        STOPPING: begin
          h_cnt <= h_nxt;
          v_cnt <= v_nxt;
          if (enable)
            state <= RUN;
          else if (to_idle)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed and random bench for hdmi_timing_ctrl on a tiny raster
// with inverted sync polarity, checked against a linear-position model.
module tb_hdmi_timing_ctrl;

  localparam int HA  = 4;
  localparam int HF  = 1;
  localparam int HSW = 1;
  localparam int HB  = 1;
  localparam int VA  = 3;
  localparam int VF  = 1;
  localparam int VSW = 1;
  localparam int VB  = 1;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b1;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int TOT = HT * VT;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;
  logic        frame_start;
  logic        underflow;
  logic        busy;

  hdmi_timing_ctrl_if pif ();

  hdmi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pix(pif),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start),
    .underflow(underflow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead source: the pixel value encodes its own coordinates.
  always_comb
    pif.pix_data = {pif.pix_y[7:0], pif.pix_x[7:0], 8'hA5};

  int checks = 0;
  int errors = 0;

  bit          m_active;
  int          m_pos;
  bit          m_uf;
  logic        e_de;
  logic [23:0] e_rgb;
  logic        e_hs;
  logic        e_vs;
  logic        e_fs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit pv);
    int  h;
    int  v;
    bit  req;
    bit  ending;
    rst           = r;
    enable        = e;
    pif.pix_valid = pv;
    h   = m_pos % HT;
    v   = m_pos / HT;
    req = m_active && (h < HA) && (v < VA);
    #1;
    chk("pix_req", 32'(pif.pix_req), 32'(req));
    chk("pix_x", 32'(pif.pix_x), 32'(h));
    chk("pix_y", 32'(pif.pix_y), 32'(v));
    if (r) begin
      e_de     = 1'b0;
      e_rgb    = 24'h0;
      e_hs     = ~HP;
      e_vs     = ~VP;
      e_fs     = 1'b0;
      m_uf     = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      e_de  = req;
      e_rgb = (req && pv) ? {8'(v), 8'(h), 8'hA5} : 24'h0;
      e_hs  = (m_active && h >= HA + HF && h < HA + HF + HSW)
              ? HP : ~HP;
      e_vs  = (m_active && v >= VA + VF && v < VA + VF + VSW)
              ? VP : ~VP;
      e_fs  = m_active && (m_pos == 0);
      ending = m_active && (m_pos == TOT - 1) && !e;
      if (!m_active || ending)
        m_uf = 1'b0;
      else if (req && !pv)
        m_uf = 1'b1;
      if (!m_active) begin
        m_active = e;
        m_pos    = 0;
      end else if (ending) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_pos = (m_pos + 1) % TOT;
      end
    end
    @(posedge clk);
    #1;
    chk("de", 32'(de), 32'(e_de));
    chk("rgb", 32'(rgb), 32'(e_rgb));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("busy", 32'(busy), 32'(m_active));
  endtask

  initial begin
    m_active      = 1'b0;
    m_pos         = 0;
    m_uf          = 1'b0;
    rst           = 1'b1;
    enable        = 1'b0;
    pif.pix_valid = 1'b1;
    @(posedge clk);
    #1;

    // reset values and idle hold
    step(1, 0, 1);
    step(1, 1, 1);
    repeat (3) step(0, 0, 1);

    // continuous frames with every pixel available
    repeat (3 * TOT + 2) step(0, 1, 1);

    // random underflows
    repeat (TOT) step(0, 1, $urandom_range(0, 3) != 0);

    // drop enable mid-frame, then re-raise while stopping
    repeat (10) step(0, 1, 1);
    repeat (8) step(0, 0, 1);
    repeat (TOT) step(0, 1, $urandom_range(0, 5) != 0);

    // let the frame finish and sit idle
    repeat (2 * TOT) step(0, 0, 1);

    // enable low exactly on the last cycle of a frame
    step(0, 1, 1);
    for (int i = 0; i < 2 * TOT; i++) begin
      if (m_active && m_pos == TOT - 1)
        break;
      step(0, 1, 1);
    end
    step(0, 0, 1);
    repeat (4) step(0, 0, 1);

    // reset in the middle of a frame, then restart
    repeat (20) step(0, 1, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    repeat (TOT + 3) step(0, 1, 1);

    // random enable, valid and occasional reset
    begin
      bit en;
      en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 24) == 0)
          en = ~en;
        step($urandom_range(0, 199) == 0, en,
             $urandom_range(0, 7) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_timing_ctrl.md
HDMI_TIMING_CTRL -- requirements
Module: hdmi_timing_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  pixel clock; the only clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  run request
- pix_req  out  1  pixel fetch strobe
- pix_x  out  12  column of the requested pixel
- pix_y  out  12  line of the requested pixel
- pix_data  in  24  {R,G,B} pixel returned by the source
- pix_valid  in  1  pix_data is valid
- hsync  out  1  registered hsync, to the TMDS encoder
- vsync  out  1  registered vsync, to the TMDS encoder
- de  out  1  registered data enable, to the TMDS encoder
- rgb  out  24  registered pixel, to the TMDS encoder
- frame_start  out  1  one-cycle frame marker
- underflow  out  1  sticky underflow flag
- busy  out  1  frame in progress

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-004 The horizontal counter h_cnt SHALL count 0..H_TOTAL-1 in RUN and STOPPING, wrapping to 0; v_cnt SHALL increment on each h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-005 Region order per line SHALL be active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical regions SHALL follow the same order on v_cnt.
REQ-006 pix_req SHALL be combinational and high iff state is not IDLE, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; pix_x=h_cnt and pix_y=v_cnt in that cycle.
REQ-007 The source SHALL return the pixel in the same cycle as pix_req (show-ahead FIFO semantics); the block SHALL sample pix_data only when pix_req is high.
REQ-008 hsync, vsync, de and rgb SHALL be registered one cycle after the counters: de(t+1)=pix_req(t); hsync is HS_POL while h_cnt is in the sync region, else ~HS_POL; vsync is VS_POL while v_cnt is in the sync region, else ~VS_POL.
REQ-009 rgb SHALL be pix_data if pix_req&&pix_valid, 24'h000000 if pix_req&&!pix_valid, and 24'h000000 whenever de is low.
REQ-010 underflow SHALL be set on the cycle after any pix_req&&!pix_valid and held until rst or until entry to IDLE.
REQ-011 frame_start SHALL pulse for one cycle aligned with the first de of each frame, i.e. registered from h_cnt==0&&v_cnt==0 in RUN.
REQ-012 The FSM SHALL have states IDLE, RUN and STOPPING:
- IDLE->RUN when enable=1; counting starts at h=0,v=0 in the next cycle.
- RUN->STOPPING when enable=0 mid-frame.
- RUN->IDLE directly when enable=0 on the last cycle (h=H_TOTAL-1, v=V_TOTAL-1).
- STOPPING->IDLE after the last cycle of the current frame.
- STOPPING->RUN if enable returns to 1 before the frame ends, with no counter disturbance.
REQ-013 In IDLE, the counters SHALL hold at 0, pix_req, de and frame_start SHALL be 0, and syncs SHALL sit at their inactive levels; busy SHALL be 1 in RUN and STOPPING.
REQ-014 A full frame SHALL never be truncated by enable; only rst aborts mid-frame.

Reset
REQ-015 On rst=1 at a clk edge: state=IDLE, h_cnt=v_cnt=0, de=0, rgb=0, frame_start=0, underflow=0, busy=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-016 rst SHALL take priority over enable and override any operation in progress.
REQ-017 The first pix_req after reset SHALL occur no earlier than the cycle after enable is sampled high.

Verification
REQ-018 Defaults, enable held high, pix_valid=1 -> de high 640 clocks per line on lines 0..479; hsync low at h 656..751; vsync low on lines 490..491; frame period 420000 clocks.
REQ-019 pix_data=={pix_y[7:0],pix_x[7:0],8'hA5} -> rgb equals the value requested on the previous cycle for every de cycle; frame_start coincides with rgb=24'h0000A5.
REQ-020 pix_valid forced low for one request at (x=10,y=3) -> rgb=0 for that pixel; underflow rises on the next cycle and stays 1 until enable is low through a frame end.
REQ-021 enable dropped at line 100 -> frame completes through v=524, h=799; then busy=0, syncs inactive, no further pix_req; enable re-raised during STOPPING -> next frame starts seamlessly.
REQ-022 rst pulsed at h=300, v=200 -> all outputs match REQ-015 on the next cycle, and a new frame begins at 0,0 once enable is sampled.
REQ-023 HS_POL=1, VS_POL=1, small timing (4/1/1/1, 3/1/1/1) -> sync polarity inverted, H_TOTAL=7, V_TOTAL=6; counter wrap and frame_start verified exhaustively.
